fir_out_shaper: RTL and testbench
=================================

# fir_out_shaper

Output stage directly downstream of the parallel 16-tap FIR. It takes the 31-bit FIR result and its one-cycle valid, rounds and scales it to 16 bits, saturates, and optionally decimates. Results are buffered in a small FIFO and presented on a valid/ready stream with a frame-last marker for the FFT front end. The stage also keeps saturation and drop statistics for the debug/HDMI overlay.

## Interface
- SHIFT, 11: arithmetic right shift applied after rounding; legal 1..20. The coefficient sum is about 2^11.
- DECIM, 1: keep 1 of every DECIM valid input samples; legal 1..16.
- FRAME_LEN, 1024: samples per FFT frame; a power of two, 2..4096.
- DEPTH, 16: FIFO depth; a power of two, 4..64.
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- fir_valid  in  1  single-cycle strobe; fir_yout is valid in this cycle
- fir_yout  in  31  FIR result, two's-complement signed
- m_valid  out  1  output word available
- m_ready  in  1  downstream accepts the word
- m_data  out  16  scaled sample, signed
- m_last  out  1  high on the last word of each frame
- sat_cnt  out  16  count of saturated kept samples; holds at 0xFFFF
- drop_flag  out  1  sticky; set when a kept sample is lost to a full FIFO
- clr_stats  in  1  synchronous clear of sat_cnt and drop_flag

## Operation
- **S1 (round).** On fir_valid, register r = (sext32(fir_yout) + 2^(SHIFT-1)) >>> SHIFT.
  - Rounding is half toward +inf.
  - Intermediate width is 32 bits, so no overflow before the shift.
- **S2 (saturate/decimate).**
  - Clamp r to [-32768, 32767].
  - A decimation counter runs 0..DECIM-1 and advances on every S1 valid. The sample is kept only when the counter is 0.
  - sat_cnt increments only for kept samples that were clamped.
- **S3 (enqueue).**
  - Each kept sample is written to the FIFO as {last, data}.
  - A frame counter runs 0..FRAME_LEN-1 and advances only on a successful write. last = (count == FRAME_LEN-1).
- **FIFO full.**
  - A write is accepted when not full, or when full with a pop (m_valid & m_ready) in the same cycle.
  - Otherwise the sample is discarded, drop_flag is set, and the frame counter does not advance.
- **Output.**
  - m_valid = FIFO not empty.
  - m_data and m_last show the head entry and stay stable until the handshake.
  - A pop occurs when m_valid & m_ready.
- **clr_stats.** Clears the counters in the next cycle. If clr_stats and a saturation event coincide, the clear wins.
- **Reset.** All of the following return to 0 on rstn low, at any time, including mid-frame:
  - outputs: m_valid, m_data, m_last, sat_cnt, drop_flag
  - internal state: FIFO pointers, decimation counter, frame counter
- **Restart.** The first sample after reset starts a new frame at decimation phase 0.

## Timing
- Latency is 3 cycles from fir_valid in cycle N to m_valid in N+3, with the FIFO empty (S1 at N+1, S2 at N+2, write at N+3).
- Back-to-back fir_valid is allowed, at one sample per cycle. Sustained throughput is 1 sample per cycle when m_ready stays high.
- m_valid must not depend combinationally on m_ready.
- Reading from an empty FIFO never happens, because m_valid is 0.
- A simultaneous write and pop when empty does not bypass: the word appears on the next cycle.

## Structure
- Package fir_out_pkg holds:
  - OUT_W=16, IN_W=31, SAT_MAX/SAT_MIN constants
  - the {last, data} entry typedef
- Sub-module sync_fifo: a parameterised width/depth synchronous FIFO with full, empty and count. It is reused for the FFT input buffering.

## Test plan
- **Rounding and scaling** (SHIFT=11, DECIM=1): fir_yout=204800 gives 100; 1024 gives 1; -1024 gives 0; -1025 gives -1. Each appears 3 cycles after its fir_valid, with m_ready=1.
- **Saturation:** fir_yout=2^30-1 gives 32767 and -2^30 gives -32768. sat_cnt reads 2; clr_stats then clears it to 0.
- **Decimation** (DECIM=4): 12 consecutive valids with values 2048*k, k=0..11, give only 0, 4, 8 on the output.
- **Frame marker** (FRAME_LEN=8): 16 samples give m_last high on the 8th and 16th handshakes only. The frame restarts after a mid-frame rstn pulse.
- **Backpressure** (DEPTH=16, m_ready=0, 20 valids):
  - The first 16 are stored and the last 4 are dropped; drop_flag=1.
  - Raising m_ready drains exactly 16 words in order.
  - A full FIFO with a simultaneous pop and write loses nothing.
- **Reset mid-operation:** assert rstn low with the FIFO half full. m_valid drops at once and sat_cnt=0; after release, the next sample appears 3 cycles after its fir_valid.

Source files
------------

// File: rtl/fir_out_pkg.sv
// Shared types and constants for the FIR output shaper and its FIFO.
package fir_out_pkg;

   localparam int OUT_W = 16;
   localparam int IN_W  = 31;
   localparam int ACC_W = 32;

   localparam logic signed [ACC_W-1:0] SAT_MAX = 32'sd32767;
   localparam logic signed [ACC_W-1:0] SAT_MIN = -32'sd32768;

   typedef struct packed {
      logic                    last;
      logic signed [OUT_W-1:0] data;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/fir_out_shaper_sync_fifo.sv
// Generic synchronous FIFO with full/empty/count; the head word is visible on rd_data.
module sync_fifo #(
   parameter int DATA_W = 17,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              do_wr;
   logic              do_rd;

   // Extra pointer MSB distinguishes full from empty.
   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_rd   = rd_en & ~empty;
   assign do_wr   = wr_en & (~full | do_rd);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/fir_out_shaper.sv
// FIR output stage: round/scale to 16 bits, saturate, decimate, frame-mark and
// buffer into a valid/ready stream, with saturation and drop statistics.
module fir_out_shaper
   import fir_out_pkg::*;
#(
   parameter int SHIFT     = 11,
   parameter int DECIM     = 1,
   parameter int FRAME_LEN = 1024,
   parameter int DEPTH     = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    fir_valid,
   input  logic signed [IN_W-1:0]  fir_yout,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic signed [OUT_W-1:0] m_data,
   output logic                    m_last,
   output logic [15:0]             sat_cnt,
   output logic                    drop_flag,
   input  logic                    clr_stats
);

   localparam int                      FW       = $clog2(FRAME_LEN);
   localparam int                      CW       = $clog2(DEPTH) + 1;
   localparam logic [4:0]              DEC_LAST = 5'(DECIM - 1);
   localparam logic [FW-1:0]           FRM_LAST = FW'(FRAME_LEN - 1);
   localparam logic signed [ACC_W-1:0] HALF     = ACC_W'(1) <<< (SHIFT - 1);

   function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [IN_W-1:0] x);
      logic signed [ACC_W-1:0] t;
      t = {{(ACC_W-IN_W){x[IN_W-1]}}, x};
      t = t + HALF;
      return t >>> SHIFT;
   endfunction

   function automatic logic is_sat(input logic signed [ACC_W-1:0] r);
      return (r > SAT_MAX) || (r < SAT_MIN);
   endfunction

   function automatic logic signed [OUT_W-1:0] clamp(input logic signed [ACC_W-1:0] r);
      if (r > SAT_MAX) return SAT_MAX[OUT_W-1:0];
      if (r < SAT_MIN) return SAT_MIN[OUT_W-1:0];
      return r[OUT_W-1:0];
   endfunction

   logic signed [ACC_W-1:0] r_p1;
   logic                    vld_p1;
   logic signed [OUT_W-1:0] data_p2;
   logic                    vld_p2;
   logic                    keep_p1;
   logic [4:0]              dec_cnt;
   logic [FW-1:0]           frm_cnt;
   logic                    pop;
   logic                    wr_ok;
   logic                    full;
   logic                    empty;
   logic [CW-1:0]           fifo_cnt;
   entry_t                  wr_entry;
   entry_t                  head;

   // S1: round and scale
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) vld_p1 <= 1'b0;
      else       vld_p1 <= fir_valid;
   end

   always_ff @(posedge clk) begin
      if (fir_valid) r_p1 <= round_shift(fir_yout);
   end

   // S2: saturate and decimate
   assign keep_p1 = vld_p1 && (dec_cnt == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_p2  <= 1'b0;
         dec_cnt <= '0;
         sat_cnt <= '0;
      end else begin
         vld_p2 <= keep_p1;
         if (vld_p1) dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 5'd1;
         if (clr_stats)
            sat_cnt <= '0;
         else if (keep_p1 && is_sat(r_p1) && sat_cnt != 16'hFFFF)
            sat_cnt <= sat_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (keep_p1) data_p2 <= clamp(r_p1);
   end

   // S3: enqueue; a full FIFO still accepts when the head leaves this cycle
   assign pop      = m_valid & m_ready;
   assign wr_ok    = vld_p2 & (~full | pop);
   assign wr_entry = '{last: (frm_cnt == FRM_LAST), data: data_p2};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         frm_cnt   <= '0;
         drop_flag <= 1'b0;
      end else begin
         if (wr_ok) frm_cnt <= (frm_cnt == FRM_LAST) ? '0 : frm_cnt + FW'(1);
         if (clr_stats)
            drop_flag <= 1'b0;
         else if (vld_p2 && !wr_ok)
            drop_flag <= 1'b1;
      end
   end

   sync_fifo #(
      .DATA_W (ENTRY_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (wr_ok),
      .wr_data (wr_entry),
      .rd_en   (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (fifo_cnt)
   );

   assign m_valid = ~empty;
   assign m_data  = m_valid ? head.data : '0;
   assign m_last  = m_valid & head.last;

   a_fifo_bound: assert property (@(posedge clk) disable iff (!rstn) fifo_cnt <= CW'(DEPTH));

endmodule

// File: tb/tb_fir_out_shaper.sv
// Bench for fir_out_shaper: directed tables and sequences plus a randomized run
// against a queue-based transaction model.
module tb_fir_out_shaper;

   localparam int SHIFT = 11;
   localparam int FL    = 8;
   localparam int DEPTH = 16;

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic               fir_valid = 1'b0;
   logic signed [30:0] fir_yout = '0;
   logic               m_ready = 1'b0;
   logic               clr_stats = 1'b0;

   logic               a_valid, a_last, a_drop;
   logic signed [15:0] a_data;
   logic [15:0]        a_sat;
   logic               d_valid, d_last, d_drop;
   logic signed [15:0] d_data;
   logic [15:0]        d_sat;

   fir_out_shaper #(.SHIFT(SHIFT), .DECIM(1), .FRAME_LEN(FL), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rstn(rstn), .fir_valid(fir_valid), .fir_yout(fir_yout),
      .m_valid(a_valid), .m_ready(m_ready), .m_data(a_data), .m_last(a_last),
      .sat_cnt(a_sat), .drop_flag(a_drop), .clr_stats(clr_stats));

   fir_out_shaper #(.SHIFT(SHIFT), .DECIM(4), .FRAME_LEN(FL), .DEPTH(DEPTH)) u_dec (
      .clk(clk), .rstn(rstn), .fir_valid(fir_valid), .fir_yout(fir_yout),
      .m_valid(d_valid), .m_ready(m_ready), .m_data(d_data), .m_last(d_last),
      .sat_cnt(d_sat), .drop_flag(d_drop), .clr_stats(clr_stats));

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   int qa_d[$];
   bit qa_l[$];
   int qd_d[$];

   typedef struct { logic signed [30:0] x; int want; bit sat; } rvec_t;
   rvec_t rt[10];

   typedef struct { int data; bit last; } word_t;
   typedef struct { int due; int data; } pend_t;
   word_t mq[$];
   pend_t mp[$];
   int    cyc, frm_m, sat_m;
   bit    drop_m;

   task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rstn = 1'b0; fir_valid = 1'b0; m_ready = 1'b0; clr_stats = 1'b0;
      tick(); tick();
      rstn = 1'b1;
      tick();
   endtask

   // Record handshakes due at the coming edge, then apply one input cycle.
   task automatic step(input logic v, input logic signed [30:0] x);
      if (a_valid && m_ready) begin qa_d.push_back(a_data); qa_l.push_back(a_last); end
      if (d_valid && m_ready) qd_d.push_back(d_data);
      fir_valid = v; fir_yout = x;
      tick();
      fir_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 31'sd0);
   endtask

   task automatic clear_caps();
      qa_d.delete(); qa_l.delete(); qd_d.delete();
   endtask

   function automatic int cap_a(input int i);
      return (i < qa_d.size()) ? qa_d[i] : -999999;
   endfunction

   // Model: rounded/clamped words reach the FIFO two edges after their input edge.
   task automatic rnd_cycle(input bit v, input logic signed [30:0] x, input bit rdy);
      word_t  w;
      pend_t  p;
      longint rl;
      bit     pop;
      chk("rnd_valid", a_valid, mq.size() != 0);
      if (mq.size() != 0 && a_valid) begin
         chk("rnd_data", a_data, mq[0].data);
         chk("rnd_last", a_last, mq[0].last);
      end
      m_ready = rdy; fir_valid = v; fir_yout = x;
      @(posedge clk);
      cyc++;
      pop = (mq.size() != 0) && rdy;
      if (mp.size() != 0 && mp[0].due == cyc) begin
         p = mp.pop_front();
         if (mq.size() < DEPTH || pop) begin
            w.data = p.data; w.last = (frm_m == FL - 1);
            mq.push_back(w);
            frm_m = (frm_m + 1) % FL;
         end else drop_m = 1'b1;
      end
      if (pop) void'(mq.pop_front());
      if (v) begin
         rl = (longint'(x) + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
         if (rl > 32767 || rl < -32768) begin
            if (sat_m < 65535) sat_m++;
            rl = (rl > 32767) ? 32767 : -32768;
         end
         p.due = cyc + 2; p.data = int'(rl);
         mp.push_back(p);
      end
      @(negedge clk);
      fir_valid = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int exp_sat;
      rt[0] = '{31'sd204800,     100,    1'b0};
      rt[1] = '{31'sd1024,       1,      1'b0};
      rt[2] = -31'sd1024 == -31'sd1024 ? '{-31'sd1024, 0, 1'b0} : '{-31'sd1024, 0, 1'b0};
      rt[3] = '{-31'sd1025,      -1,     1'b0};
      rt[4] = '{31'h3FFF_FFFF,   32767,  1'b1};
      rt[5] = '{31'h4000_0000,   -32768, 1'b1};
      rt[6] = '{-31'sd3073,      -2,     1'b0};
      rt[7] = '{31'sd67106816,   32767,  1'b0};
      rt[8] = '{31'sd67107840,   32767,  1'b1};
      rt[9] = '{-31'sd67110913,  -32768, 1'b1};

      // Reset state
      tick();
      chk("rst_valid", a_valid, 0);
      chk("rst_data", a_data, 0);
      chk("rst_last", a_last, 0);
      chk("rst_sat", a_sat, 0);
      chk("rst_drop", a_drop, 0);
      chk("rst_dec_state", {d_valid, d_last, d_drop, d_sat}, 0);
      do_reset();

      // Rounding, scaling, saturation, with exact 3-cycle latency
      m_ready = 1'b1;
      exp_sat = 0;
      foreach (rt[i]) begin
         step(1'b1, rt[i].x);
         chk($sformatf("lat1[%0d]", i), a_valid, 0);
         step(1'b0, 31'sd0);
         chk($sformatf("lat2[%0d]", i), a_valid, 0);
         step(1'b0, 31'sd0);
         chk($sformatf("lat3[%0d]", i), a_valid, 1);
         chk($sformatf("round[%0d]", i), a_data, rt[i].want);
         step(1'b0, 31'sd0);
         if (rt[i].sat) exp_sat++;
      end
      chk("sat_cnt", a_sat, exp_sat);
      clr_stats = 1'b1; step(1'b0, 31'sd0); clr_stats = 1'b0;
      chk("sat_clr", a_sat, 0);
      step(1'b1, 31'h3FFF_FFFF);
      clr_stats = 1'b1; step(1'b0, 31'sd0); clr_stats = 1'b0;
      chk("clr_wins", a_sat, 0);
      step(1'b0, 31'sd0);
      chk("clr_wins_data", a_data, 32767);
      step(1'b1, 31'h4000_0000);
      idle(3);
      chk("sat_resume", a_sat, 1);

      // Decimation by 4
      do_reset();
      m_ready = 1'b1;
      clear_caps();
      for (int k = 0; k < 12; k++) step(1'b1, 31'(2048 * k));
      idle(8);
      chk("dec_count", qd_d.size(), 3);
      for (int i = 0; i < 3; i++)
         chk($sformatf("dec[%0d]", i), (i < qd_d.size()) ? qd_d[i] : -999999, 4 * i);

      // Frame marker, then restart after a mid-frame reset
      do_reset();
      m_ready = 1'b1;
      clear_caps();
      for (int k = 0; k < 16; k++) step(1'b1, 31'(2048 * (k + 1)));
      idle(6);
      chk("frm_count", qa_d.size(), 16);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("frm_data[%0d]", i), cap_a(i), i + 1);
         chk($sformatf("frm_last[%0d]", i), (i < qa_l.size()) ? qa_l[i] : 1'bx, (i == 7 || i == 15));
      end
      for (int k = 0; k < 3; k++) step(1'b1, 31'(2048 * (k + 1)));
      idle(5);
      do_reset();
      m_ready = 1'b1;
      clear_caps();
      for (int k = 0; k < 8; k++) step(1'b1, 31'(2048 * (k + 1)));
      idle(6);
      chk("restart_count", qa_d.size(), 8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("restart_last[%0d]", i), (i < qa_l.size()) ? qa_l[i] : 1'bx, (i == 7));

      // Backpressure: fill, overflow, drain
      do_reset();
      clear_caps();
      for (int k = 0; k < 20; k++) step(1'b1, 31'(2048 * (k + 1)));
      idle(4);
      chk("bp_valid", a_valid, 1);
      chk("bp_drop", a_drop, 1);
      chk("bp_head", a_data, 1);
      m_ready = 1'b1;
      clear_caps();
      idle(24);
      chk("bp_drain_count", qa_d.size(), 16);
      for (int i = 0; i < 16; i++) chk($sformatf("bp_drain[%0d]", i), cap_a(i), i + 1);
      chk("bp_empty", a_valid, 0);

      // Full FIFO with simultaneous pop and write loses nothing
      clr_stats = 1'b1; step(1'b0, 31'sd0); clr_stats = 1'b0;
      chk("bp_drop_clr", a_drop, 0);
      m_ready = 1'b0;
      for (int k = 0; k < 16; k++) step(1'b1, 31'(2048 * (k + 1)));
      idle(4);
      chk("full_no_drop", a_drop, 0);
      clear_caps();
      step(1'b1, 31'(2048 * 100));
      step(1'b0, 31'sd0);
      m_ready = 1'b1;
      step(1'b0, 31'sd0);
      m_ready = 1'b0;
      step(1'b0, 31'sd0);
      chk("popwr_drop", a_drop, 0);
      m_ready = 1'b1;
      idle(22);
      chk("popwr_count", qa_d.size(), 17);
      for (int i = 0; i < 17; i++)
         chk($sformatf("popwr[%0d]", i), cap_a(i), (i < 16) ? i + 1 : 100);

      // Asynchronous reset with the FIFO half full
      do_reset();
      step(1'b1, 31'h3FFF_FFFF);
      for (int k = 0; k < 7; k++) step(1'b1, 31'(2048 * (k + 1)));
      idle(4);
      chk("mid_valid_pre", a_valid, 1);
      chk("mid_sat_pre", a_sat, 1);
      #2 rstn = 1'b0;
      #1;
      chk("mid_valid_rst", a_valid, 0);
      chk("mid_sat_rst", a_sat, 0);
      chk("mid_data_rst", a_data, 0);
      tick();
      rstn = 1'b1;
      tick();
      m_ready = 1'b1;
      step(1'b1, 31'(2048 * 7));
      chk("mid_lat1", a_valid, 0);
      step(1'b0, 31'sd0);
      chk("mid_lat2", a_valid, 0);
      step(1'b0, 31'sd0);
      chk("mid_lat3", a_valid, 1);
      chk("mid_data", a_data, 7);
      step(1'b0, 31'sd0);

      // Randomized run against the transaction model
      do_reset();
      mq.delete(); mp.delete();
      cyc = 0; frm_m = 0; sat_m = 0; drop_m = 1'b0;
      for (int n = 0; n < 1600; n++) begin
         logic signed [30:0] x;
         bit v, r;
         v = ($urandom_range(0, 9) < 7);
         r = (n < 800) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 9);
         if ($urandom_range(0, 3) == 0) x = 31'($urandom);
         else x = 31'(int'($urandom_range(0, 1 << 27)) - (1 << 26));
         rnd_cycle(v, x, r);
      end
      for (int n = 0; n < 40; n++) rnd_cycle(1'b0, 31'sd0, 1'b1);
      chk("rnd_sat_cnt", a_sat, sat_m);
      chk("rnd_drop", a_drop, drop_m);
      chk("rnd_drained", a_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
